// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit and the memory it drives.
// Width defaults and the FSM state encoding live here so both sides agree.
package mem_pkg;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store unit between a processor request port and a byte-addressed word memory.
// Byte stores are done as read-modify-write so the neighbouring byte survives.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out
);

  mau_state_e state, state_nxt;

  logic       byte_q;
  logic       signed_q;
  logic [7:0] wbyte_q;
  logic [7:0] rd_hi;
  logic [DATA_W-1:0] load_val;

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // A byte lives in the high half of the word addressed by its own byte address.
  assign rd_hi    = mem_data_out[DATA_W-1 -: 8];
  assign load_val = byte_q ? {{(DATA_W-8){signed_q & rd_hi[7]}}, rd_hi} : mem_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_write)    state_nxt = ST_READ;
          else if (req_byte) state_nxt = ST_RMW_RD;
          else               state_nxt = ST_WRITE;
        end
      end
      ST_READ:   state_nxt = ST_RESP;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RMW_RD: state_nxt = ST_RMW_WR;
      ST_RMW_WR: state_nxt = ST_RESP;
      ST_RESP:   if (resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Memory-side outputs are all registered; mem_addr only moves on a new handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q      <= 1'b0;
      signed_q    <= 1'b0;
      wbyte_q     <= 8'h00;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            byte_q   <= req_byte;
            signed_q <= req_signed;
            wbyte_q  <= req_wdata[7:0];
            mem_addr <= req_addr;
            if (req_write && !req_byte) begin
              mem_data_in <= req_wdata;
              mem_we      <= 1'b1;
            end
          end
        end
        ST_READ: resp_rdata <= load_val;
        ST_WRITE: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
        end
        ST_RMW_RD: begin
          mem_data_in <= {wbyte_q, mem_data_out[DATA_W-9:0]};
          mem_we      <= 1'b1;
        end
        ST_RMW_WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a byte-array memory on the DUT's memory port, plus a
// transaction-level byte model that predicts every response and stored byte.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NB = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0, req_signed = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_we;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    ram     [NB];
  logic [7:0]    ref_mem [NB];
  logic [AW-1:0] am1;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] exp_wdata = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  // memory contract: word A = {byte[A], byte[A-1]}
  assign am1          = mem_addr - 14'd1;
  assign mem_data_out = {ram[mem_addr], ram[am1]};
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_data_in[15:8];
      ram[am1]      <= mem_data_in[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // whenever the memory is written, address and data must match the transaction
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      chk("mem_addr_at_we", 32'(mem_addr), 32'(cur_addr));
      chk("mem_data_in_at_we", 32'(mem_data_in), 32'(exp_wdata));
    end
  end

  function automatic logic [15:0] model_word(input logic [AW-1:0] a);
    logic [AW-1:0] p;
    p = a - 14'd1;
    return {ref_mem[a], ref_mem[p]};
  endfunction

  task automatic do_req(input logic w, input logic b, input logic s,
                        input logic [AW-1:0] a, input logic [15:0] wd,
                        input int hold, output logic [15:0] got);
    logic [15:0]   exp_r;
    logic [AW-1:0] p;
    int lat, we_cnt, n;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_before_req", 32'(req_ready), 32'd1);
    p = a - 14'd1;
    if (w)      exp_r = 16'h0000;
    else if (b) exp_r = s ? {{8{ref_mem[a][7]}}, ref_mem[a]} : {8'h00, ref_mem[a]};
    else        exp_r = model_word(a);
    lat       = (w && b) ? 3 : 2;
    cur_addr  = a;
    exp_wdata = b ? {wd[7:0], ref_mem[p]} : wd;
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = 16'($urandom);
    req_addr  = 14'($urandom);
    if (w) begin
      if (b) ref_mem[a] = wd[7:0];
      else begin ref_mem[a] = wd[15:8]; ref_mem[p] = wd[7:0]; end
    end
    we_cnt = 0;
    got = 16'hxxxx;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("resp_valid_latency", 32'(resp_valid), 32'(k == lat));
      if (mem_we) we_cnt++;
      if (k == lat) got = resp_rdata;
    end
    chk("mem_we_cycles", 32'(we_cnt), 32'(w));
    chk("resp_rdata", 32'(got), 32'(exp_r));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("resp_valid_hold", 32'(resp_valid), 32'd1);
      chk("resp_rdata_hold", 32'(resp_rdata), 32'(exp_r));
      chk("req_ready_hold", 32'(req_ready), 32'd0);
      chk("mem_we_hold", 32'(mem_we), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_valid_after", 32'(resp_valid), 32'd0);
    chk("req_ready_after", 32'(req_ready), 32'd1);
    if (w) begin
      chk("ram_byte_a", 32'(ram[a]), 32'(ref_mem[a]));
      chk("ram_byte_a_minus_1", 32'(ram[p]), 32'(ref_mem[p]));
    end
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  bv;
    for (int i = 0; i < NB; i++) begin
      bv = 8'($urandom);
      ram[i] = bv;
      ref_mem[i] = bv;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);

    // directed cases with hand-computed expectations
    do_req(1'b1, 1'b0, 1'b0, 14'h0011, 16'h1234, 0, got);
    chk("lit_ram_11", 32'(ram[14'h11]), 32'h12);
    chk("lit_ram_10", 32'(ram[14'h10]), 32'h34);
    do_req(1'b0, 1'b0, 1'b0, 14'h0011, 16'h0000, 0, got);
    chk("lit_load_1234", 32'(got), 32'h1234);
    do_req(1'b1, 1'b1, 1'b0, 14'h0011, 16'h55AB, 1, got);
    do_req(1'b0, 1'b0, 1'b0, 14'h0011, 16'h0000, 0, got);
    chk("lit_load_AB34", 32'(got), 32'hAB34);
    do_req(1'b0, 1'b1, 1'b1, 14'h0011, 16'h0000, 0, got);
    chk("lit_sbyte_FFAB", 32'(got), 32'hFFAB);
    do_req(1'b0, 1'b1, 1'b0, 14'h0011, 16'h0000, 0, got);
    chk("lit_ubyte_00AB", 32'(got), 32'h00AB);
    do_req(1'b1, 1'b0, 1'b0, 14'h0000, 16'hBEEF, 0, got);
    chk("lit_wrap_0000", 32'(ram[14'h0000]), 32'hBE);
    chk("lit_wrap_3FFF", 32'(ram[14'h3FFF]), 32'hEF);
    do_req(1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 5, got);
    chk("lit_hold_load_BEEF", 32'(got), 32'hBEEF);

    // reset during the read half of a byte store
    cur_addr = 14'h0200;
    req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
    req_addr = 14'h0200; req_wdata = 16'h00C3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid_after", 32'(resp_valid), 32'd0);
    chk("abort_mem_we_after", 32'(mem_we), 32'd0);
    chk("abort_ram_untouched", 32'(ram[14'h0200]), 32'(ref_mem[14'h0200]));

    // randomized traffic against the byte model
    for (int t = 0; t < 200; t++) begin
      logic [AW-1:0] a;
      a = (t % 10 == 0) ? 14'($urandom_range(0, 1)) : 14'($urandom);
      do_req(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom),
             int'($urandom_range(0, 3)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 14, memory byte-address width.
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  processor request present.
REQ-006 req_ready  out  1  unit can accept a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_byte  in  1  1 = byte access, 0 = word access.
REQ-009 req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  store data; byte stores use bits [7:0].
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  processor accepts response.
REQ-014 resp_rdata  out  DATA_W  load result; 0 for stores.
REQ-015 mem_addr  out  ADDR_W  address to memory.
REQ-016 mem_data_in  out  DATA_W  write data to memory.
REQ-017 mem_we  out  1  memory write enable, level-sensitive.
REQ-018 mem_data_out  in  DATA_W  combinational read data from memory.

Function
REQ-019 Memory contract: word at address A = {byte[A], byte[A-1]}; write stores [15:8] to byte[A] and [7:0] to byte[A-1]; A-1 wraps modulo 2^ADDR_W.
REQ-020 Byte access at B targets byte[B] = high byte of word at B; mem_addr SHALL always equal the latched req_addr, no alignment check.
REQ-021 FSM states: IDLE, READ, WRITE, RMW_RD, RMW_WR, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready on a rising edge; all request fields are latched then.
REQ-023 Transitions from IDLE on handshake: load -> READ; word store -> WRITE; byte store -> RMW_RD.
REQ-024 READ: drive mem_addr for one cycle, capture mem_data_out at cycle end, -> RESP.
REQ-025 WRITE: mem_we=1 for exactly one cycle with mem_data_in=req_wdata, -> RESP.
REQ-026 RMW_RD: one read cycle capturing the word; RMW_WR: mem_we=1 one cycle, mem_data_in={req_wdata[7:0], captured[7:0]}, -> RESP.
REQ-027 Latency: resp_valid asserted 2 cycles after handshake for loads and word stores, 3 for byte stores.
REQ-028 Load data: word -> captured word; byte -> captured[15:8] extended per req_signed.
REQ-029 RESP: resp_valid=1 and resp_rdata held stable until resp_valid & resp_ready, then -> IDLE; no new request accepted in the same cycle.
REQ-030 mem_addr, mem_data_in, mem_we SHALL be driven from registers only; mem_addr/mem_data_in stable for the whole cycle mem_we is 1; mem_we=0 outside WRITE/RMW_WR.
REQ-031 mem_addr SHALL hold its last value in IDLE/RESP (no spurious toggling).

Reset
REQ-032 rst SHALL immediately force IDLE, req_ready=1 upon release, resp_valid=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_data_in=0.
REQ-033 Reset mid-transaction SHALL abort it with no response; only the in-flight word may be left partially written.

Structure
REQ-034 Package mem_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state enum, shared with memory.
REQ-035 Single flat module; no sub-module required.

Verification
REQ-036 Word store 0x1234 to addr 0x0011, then word load 0x0011 -> resp_rdata=0x1234; byte[0x11]=0x12, byte[0x10]=0x34.
REQ-037 After REQ-036, byte store 0xAB to 0x0011 -> word 0x0011 reads 0xAB34; mem_we high exactly one cycle, 3-cycle latency.
REQ-038 Byte load 0x0011 with req_signed=1 -> 0xFFAB; with req_signed=0 -> 0x00AB.
REQ-039 Word store 0xBEEF to addr 0x0000 -> byte[0x0000]=0xBE, byte[0x3FFF]=0xEF (wrap).
REQ-040 Hold resp_ready=0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, next request accepted only after response handshake.
REQ-041 Assert rst during RMW_RD -> mem_we never asserted, resp_valid=0, req_ready=1 the cycle after release.
